// File: rtl/instruction_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_pkg
// Shared definitions for the instruction fetch unit:
//   - fetch_state_e    : fetch FSM state encoding (IDLE, FETCH, WAIT, HOLD)
//   - NOP_INSTR        : canonical no-op (addi x0,x0,0) shown when nothing is held
//   - DEFAULT_RESET_PC : default first fetch address after reset
//   - field positions  : bit ranges of op / funct3 / funct7 inside an instruction
//   - helpers          : field extraction, word alignment, misalignment test
// -----------------------------------------------------------------------------
package instruction_fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_WAIT  = 2'd2,
      ST_HOLD  = 2'd3
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] PC_STEP          = 32'd4;

   // Instruction field positions (RISC-V base encoding).
   localparam int OP_LSB     = 0;
   localparam int OP_W       = 7;
   localparam int FUNCT3_LSB = 12;
   localparam int FUNCT3_W   = 3;
   localparam int FUNCT7_LSB = 25;
   localparam int FUNCT7_W   = 7;

   function automatic logic [6:0] instr_op(input logic [31:0] w);
      return w[OP_LSB +: OP_W];
   endfunction

   function automatic logic [2:0] instr_funct3(input logic [31:0] w);
      return w[FUNCT3_LSB +: FUNCT3_W];
   endfunction

   function automatic logic [6:0] instr_funct7(input logic [31:0] w);
      return w[FUNCT7_LSB +: FUNCT7_W];
   endfunction

   // Clears the byte-offset bits so every fetch address is word aligned.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

   function automatic logic is_misaligned(input logic [31:0] addr);
      return (addr[1:0] != 2'b00);
   endfunction

endpackage : instruction_fetch_pkg

// File: rtl/instruction_fetch_pc_reg.sv
// -----------------------------------------------------------------------------
// fetch_pc_reg
// Program counter register and its next-pc selection.
//   pc_d selection (highest priority first):
//     rst                      -> RESET_PC
//     advance && branch_taken  -> word-aligned branch_target
//     advance                  -> pc + 4 (wraps 32'hFFFFFFFC -> 0)
//     otherwise                -> hold
// Ports:
//   clk           in   clock, rising edge
//   rst           in   synchronous active-high reset
//   advance       in   the held instruction is being consumed this cycle
//   branch_taken  in   the consumed instruction redirects the pc
//   branch_target in   redirect address (low two bits are dropped)
//   pc            out  current fetch address
// -----------------------------------------------------------------------------
module fetch_pc_reg
   import instruction_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        advance,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] pc
);

   logic [31:0] pc_q;
   logic [31:0] pc_d;

   always_comb begin
      pc_d = pc_q;
      if (rst) begin
         pc_d = RESET_PC;
      end else if (advance) begin
         if (branch_taken) begin
            pc_d = word_align(branch_target);
         end else begin
            // Plain 32-bit add: carry out is discarded, so the top word wraps to 0.
            pc_d = pc_q + PC_STEP;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule : fetch_pc_reg

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Fetches one instruction at a time from instruction memory, holds it for
// decode, and steps the pc (sequential or branch redirect) once it is consumed.
//
// Handshakes (both sides): a transfer happens on a rising edge where valid and
// ready are both 1. Once valid is raised it stays raised, with its payload
// unchanged, until that transfer. imem_rsp_valid has no ready: the unit only
// listens for it while a request is outstanding (WAIT) and ignores it otherwise.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   imem_req_valid/ready  fetch request handshake, imem_addr = word address
//   imem_rsp_valid/data   returned instruction word (one cycle pulse)
//   instr_valid/ready     held-instruction handshake toward decode/execute
//   instr, instr_pc       held word (NOP when nothing held) and its address
//   op, funct3, funct7    fields of instr for the control unit
//   branch_taken/target   redirect for the instruction being consumed
//   misalign_err          sticky: some taken branch had a non-word target
//
// The FSM is split into state register, next-state logic and output logic.
// The state is visible on the internal signal state_q for checkers.
// -----------------------------------------------------------------------------
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [6:0]  op,
   output logic [2:0]  funct3,
   output logic [6:0]  funct7,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        misalign_err
);

   fetch_state_e state_q;
   fetch_state_e state_d;

   logic [31:0] instr_q;
   logic [31:0] instr_d;
   logic [31:0] instr_pc_q;
   logic [31:0] instr_pc_d;
   logic        misalign_q;
   logic        misalign_d;

   logic [31:0] pc;
   logic        accept_rsp;
   logic        advance_pc;

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  state_d = ST_FETCH;
         // imem_req_valid is 1 throughout FETCH, so ready alone completes it.
         ST_FETCH: if (imem_req_ready) state_d = ST_WAIT;
         ST_WAIT:  if (imem_rsp_valid) state_d = ST_HOLD;
         ST_HOLD:  if (instr_ready)    state_d = ST_FETCH;
         default:  state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      imem_req_valid = (state_q == ST_FETCH);
      instr_valid    = (state_q == ST_HOLD);
      // A response only counts while exactly one request is outstanding.
      accept_rsp     = (state_q == ST_WAIT) && imem_rsp_valid;
      // Branch inputs are meaningful only when the held instruction retires.
      advance_pc     = (state_q == ST_HOLD) && instr_ready;
   end

   // ---------------------------------------------------------------------------
   // Held instruction and sticky misalignment flag
   // ---------------------------------------------------------------------------
   always_comb begin
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      misalign_d = misalign_q;
      if (accept_rsp) begin
         instr_d    = imem_rsp_data;
         // pc is frozen from FETCH through HOLD, so it names the returned word.
         instr_pc_d = pc;
      end
      if (advance_pc && branch_taken && is_misaligned(branch_target)) begin
         misalign_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q    <= NOP_INSTR;
         instr_pc_q <= RESET_PC;
         misalign_q <= 1'b0;
      end else begin
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         misalign_q <= misalign_d;
      end
   end

   // ---------------------------------------------------------------------------
   // PC register and next-pc mux
   // ---------------------------------------------------------------------------
   fetch_pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk           (clk),
      .rst           (rst),
      .advance       (advance_pc),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .pc            (pc)
   );

   // ---------------------------------------------------------------------------
   // Output view: a NOP is presented whenever nothing is held, so decode never
   // sees a stale word; the fields always follow what is presented.
   // ---------------------------------------------------------------------------
   always_comb begin
      instr    = instr_valid ? instr_q : NOP_INSTR;
      op       = instr_op(instr);
      funct3   = instr_funct3(instr);
      funct7   = instr_funct7(instr);
      instr_pc = instr_pc_q;
   end

   assign imem_addr    = pc;
   assign misalign_err = misalign_q;

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Self-checking bench for instruction_fetch: fixed-latency timing check,
// table of instruction transactions, hand-written stall / reset-in-WAIT
// sequences, and a randomized run against a transaction-level model.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        misalign_err;

  instruction_fetch #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .op             (op),
    .funct3         (funct3),
    .funct7         (funct7),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .misalign_err   (misalign_err)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------------------------------------------------------------------
  // Helpers / driver tasks
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    instr_ready    = 1'b0;
    branch_taken   = 1'b0;
    branch_target  = 32'h0;
  endtask

  // Leaves the bench at the negedge of the first cycle after the reset edge.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_req(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (imem_req_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL %s_req_timeout: got no imem_req_valid, expected one within 8 cycles", tag);
    end
  endtask

  // Zero-wait fetch: accept immediately, respond the next cycle.
  task automatic fetch_one(input logic [31:0] data, input logic [31:0] exp_addr, input string tag);
    bit ok;
    wait_req(tag, ok);
    if (ok) begin
      check({tag, "_addr"}, imem_addr, exp_addr);
      imem_req_ready = 1'b1;
      step();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = data;
      step();
      imem_rsp_valid = 1'b0;
      check({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
    end
  endtask

  task automatic consume(input bit taken, input logic [31:0] tgt);
    instr_ready   = 1'b1;
    branch_taken  = taken;
    branch_target = tgt;
    step();
    instr_ready   = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] data;
    bit          taken;
    logic [31:0] target;
    logic [31:0] exp_addr;
    logic [6:0]  exp_op;
    logic [2:0]  exp_f3;
    logic [6:0]  exp_f7;
    bit          exp_mis;
  } vec_t;

  vec_t vecs[9];

  // Random-phase model and scoreboard.
  logic [31:0] exp_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_held;
  bit          m_idle, m_out, m_hold, m_mis;
  int          m_lat;

  initial begin
    bit          prev_fire;
    bit          exp_req, fire, cons;
    logic [31:0] tgt;
    bit          ok;

    rst = 1'b0;
    idle_inputs();
    @(negedge clk);

    vecs[0] = '{32'h00A0_0093, 1'b0, 32'h0,         32'h0000_0000, 7'h13, 3'd0, 7'h00, 1'b0};
    vecs[1] = '{32'h0020_81B3, 1'b0, 32'h0,         32'h0000_0004, 7'h33, 3'd0, 7'h00, 1'b0};
    vecs[2] = '{32'h4020_8233, 1'b0, 32'h0,         32'h0000_0008, 7'h33, 3'd0, 7'h20, 1'b0};
    vecs[3] = '{32'h0020_C2B3, 1'b0, 32'h0,         32'h0000_000C, 7'h33, 3'd4, 7'h00, 1'b0};
    vecs[4] = '{32'h0220_8863, 1'b1, 32'h0000_0040, 32'h0000_0010, 7'h63, 3'd0, 7'h01, 1'b0};
    vecs[5] = '{32'h0020_9463, 1'b1, 32'h0000_0042, 32'h0000_0040, 7'h63, 3'd1, 7'h00, 1'b1};
    vecs[6] = '{32'h0000_0013, 1'b1, 32'hFFFF_FFFC, 32'h0000_0040, 7'h13, 3'd0, 7'h00, 1'b1};
    vecs[7] = '{32'hFFF0_0093, 1'b0, 32'h0,         32'hFFFF_FFFC, 7'h13, 3'd0, 7'h7F, 1'b1};
    vecs[8] = '{32'h00A0_0093, 1'b0, 32'h0,         32'h0000_0000, 7'h13, 3'd0, 7'h00, 1'b1};

    // ---- reset state --------------------------------------------------------
    do_reset();
    check("rst_req_valid",   {31'b0, imem_req_valid}, 32'd0);
    check("rst_instr_valid", {31'b0, instr_valid},    32'd0);
    check("rst_instr",       instr,                   NOP);
    check("rst_op",          {25'b0, op},             32'h13);
    check("rst_instr_pc",    instr_pc,                RST_PC);
    check("rst_misalign",    {31'b0, misalign_err},   32'd0);

    // ---- zero-wait throughput: requests on cycles 1,4,7 ----------------------
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    prev_fire      = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      step();
      imem_rsp_valid = prev_fire;
      imem_rsp_data  = 32'h0010_0093 + c;
      check($sformatf("tput_req_c%0d", c), {31'b0, imem_req_valid}, {31'b0, (c % 3) == 1});
      if ((c % 3) == 1) check($sformatf("tput_addr_c%0d", c), imem_addr, ((c - 1) / 3) * 4);
      check($sformatf("tput_ivalid_c%0d", c), {31'b0, instr_valid}, {31'b0, (c % 3) == 0});
      prev_fire = imem_req_valid;
    end
    idle_inputs();

    // ---- table of transactions ----------------------------------------------
    do_reset();
    for (int i = 0; i < 9; i++) begin
      fetch_one(vecs[i].data, vecs[i].exp_addr, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_instr", i),  instr,              vecs[i].data);
      check($sformatf("vec%0d_op", i),     {25'b0, op},        {25'b0, vecs[i].exp_op});
      check($sformatf("vec%0d_funct3", i), {29'b0, funct3},    {29'b0, vecs[i].exp_f3});
      check($sformatf("vec%0d_funct7", i), {25'b0, funct7},    {25'b0, vecs[i].exp_f7});
      check($sformatf("vec%0d_pc", i),     instr_pc,           vecs[i].exp_addr);
      consume(vecs[i].taken, vecs[i].target);
      check($sformatf("vec%0d_mis", i),    {31'b0, misalign_err}, {31'b0, vecs[i].exp_mis});
    end

    // ---- stall with garbage on ignored inputs ---------------------------------
    fetch_one(32'h00A0_0093, 32'h0000_0004, "stall");
    for (int k = 0; k < 5; k++) begin
      instr_ready    = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
      branch_taken   = 1'b1;
      branch_target  = 32'h0000_0080;
      step();
      check($sformatf("stall_instr_%0d", k),  instr,                   32'h00A0_0093);
      check($sformatf("stall_op_%0d", k),     {25'b0, op},             32'h13);
      check($sformatf("stall_f3_%0d", k),     {29'b0, funct3},         32'd0);
      check($sformatf("stall_pc_%0d", k),     instr_pc,                32'h0000_0004);
      check($sformatf("stall_req_%0d", k),    {31'b0, imem_req_valid}, 32'd0);
      check($sformatf("stall_valid_%0d", k),  {31'b0, instr_valid},    32'd1);
    end
    idle_inputs();
    check("mis_sticky", {31'b0, misalign_err}, 32'd1);
    consume(1'b0, 32'h0);
    wait_req("after_stall", ok);
    if (ok) check("after_stall_addr", imem_addr, 32'h0000_0008);

    // ---- reset while WAIT, stale response 2 cycles later ----------------------
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rwait_ivalid0", {31'b0, instr_valid},    32'd0);
    check("rwait_instr0",  instr,                   NOP);
    check("rwait_mis",     {31'b0, misalign_err},   32'd0);
    check("rwait_req0",    {31'b0, imem_req_valid}, 32'd0);
    step();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hCAFE_BABE;
    check("rwait_req1",  {31'b0, imem_req_valid}, 32'd1);
    check("rwait_addr1", imem_addr,               RST_PC);
    step();
    imem_rsp_valid = 1'b0;
    check("rwait_ivalid2", {31'b0, instr_valid},    32'd0);
    check("rwait_req2",    {31'b0, imem_req_valid}, 32'd1);
    check("rwait_addr2",   imem_addr,               RST_PC);
    fetch_one(32'h0010_0113, RST_PC, "refetch");
    check("refetch_instr", instr,    32'h0010_0113);
    check("refetch_pc",    instr_pc, RST_PC);
    consume(1'b0, 32'h0);

    // ---- randomized run against transaction-level model ----------------------
    do_reset();
    m_pc = RST_PC; m_idle = 1'b1; m_out = 1'b0; m_hold = 1'b0; m_mis = 1'b0;
    m_lat = 0; m_held = 32'h0;
    exp_q.delete();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      exp_req = !m_idle && !m_out && !m_hold;
      check("rnd_req", {31'b0, imem_req_valid}, {31'b0, exp_req});
      if (exp_req) check("rnd_addr", imem_addr, m_pc);
      check("rnd_ivalid", {31'b0, instr_valid}, {31'b0, m_hold});
      if (m_hold) begin
        check("rnd_instr",  instr,           m_held);
        check("rnd_ipc",    instr_pc,        m_pc);
        check("rnd_op",     {25'b0, op},     {25'b0, m_held[6:0]});
        check("rnd_funct3", {29'b0, funct3}, {29'b0, m_held[14:12]});
        check("rnd_funct7", {25'b0, funct7}, {25'b0, m_held[31:25]});
      end else begin
        check("rnd_nop", instr, NOP);
      end
      check("rnd_mis", {31'b0, misalign_err}, {31'b0, m_mis});

      rst            = ($urandom_range(0, 199) == 0);
      imem_req_ready = ($urandom_range(0, 2) != 0);
      if (m_out && m_lat == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = exp_q[0];
      end else begin
        imem_rsp_valid = !m_out && ($urandom_range(0, 3) == 0);
        imem_rsp_data  = $urandom;
      end
      instr_ready  = ($urandom_range(0, 1) == 1);
      branch_taken = ($urandom_range(0, 9) < 3);
      tgt = $urandom;
      if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
      branch_target = tgt;
      fire = exp_req && imem_req_ready && !rst;
      cons = m_hold && instr_ready && !rst;

      @(posedge clk);
      if (rst) begin
        m_pc = RST_PC; m_idle = 1'b1; m_out = 1'b0; m_hold = 1'b0; m_mis = 1'b0;
        exp_q.delete();
      end else begin
        m_idle = 1'b0;
        if (m_out) begin
          if (m_lat == 0) begin
            m_held = exp_q.pop_front();
            m_hold = 1'b1;
            m_out  = 1'b0;
          end else begin
            m_lat--;
          end
        end
        if (fire) begin
          m_out = 1'b1;
          m_lat = $urandom_range(0, 3);
          exp_q.push_back($urandom);
        end
        if (cons) begin
          m_hold = 1'b0;
          if (branch_taken) begin
            if (tgt % 4 != 0) m_mis = 1'b1;
            m_pc = tgt - (tgt % 4);
          end else begin
            m_pc = m_pc + 4;
          end
        end
      end
      @(negedge clk);
    end
    rst = 1'b0;
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_instruction_fetch
